// File: rtl/seg_pkg.sv
// Shared types and defaults for the segment frame packer.
package seg_pkg;

    localparam int unsigned DefNumSeg = 8;
    localparam int unsigned DefDataW  = 32;
    localparam int unsigned DefCntW   = 16;
    localparam logic [31:0] DefPadWord = 32'h0000_0000;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } seg_state_e;

    // Index must also reach NUM_SEG (checksum slot / full count).
    function automatic int unsigned seg_idx_w(input int unsigned num_seg);
        return $clog2(num_seg + 1);
    endfunction

endpackage

// File: rtl/seg_frame_packer_if.sv
// Segment input and frame output streams of the packer.
interface seg_frame_packer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              seg_valid;
    logic [DATA_W-1:0] seg_data;
    logic              seg_ready;
    logic              seg_flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic [CNT_W-1:0]  frame_cnt;

    // Segment producer / frame consumer side.
    modport master (
        output seg_valid, seg_data, seg_flush, out_ready,
        input  seg_ready, out_valid, out_data, out_last, frame_cnt
    );

    // Packer side.
    modport slave (
        input  seg_valid, seg_data, seg_flush, out_ready,
        output seg_ready, out_valid, out_data, out_last, frame_cnt
    );
endinterface

// File: rtl/seg_frame_buf.sv
// NUM_SEG x DATA_W frame store: one write port with pad-fill from a start
// index, one registered read port with same-cycle write bypass.
module seg_frame_buf
    import seg_pkg::*;
#(
    parameter int unsigned       NUM_SEG  = DefNumSeg,
    parameter int unsigned       DATA_W   = DefDataW,
    parameter logic [DATA_W-1:0] PAD_WORD = DATA_W'(DefPadWord),
    parameter int unsigned       IDX_W    = seg_idx_w(NUM_SEG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pad_en,
    input  logic [IDX_W-1:0]  pad_start,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [NUM_SEG];
    logic [DATA_W-1:0] rd_next;

    // Storage: the written slot and the pad range never overlap.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SEG; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                mem[i] <= wr_data;
            end else if (pad_en && (IDX_W'(i) >= pad_start)) begin
                mem[i] <= PAD_WORD;
            end
        end
    end

    // Read mux; bypass covers a frame closed by a write to slot 0.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_next = mem[i];
            end
        end
        if (pad_en && (rd_idx >= pad_start)) begin
            rd_next = PAD_WORD;
        end
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_next = wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: rtl/seg_frame_packer.sv
// Segment frame packer: collects NUM_SEG segment words, then drains them
// in order. Optional macro SEG_FRAME_CHECKSUM_EN appends an XOR checksum word.
module seg_frame_packer
    import seg_pkg::*;
#(
    parameter int unsigned       NUM_SEG  = DefNumSeg,
    parameter int unsigned       DATA_W   = DefDataW,
    parameter logic [DATA_W-1:0] PAD_WORD = DATA_W'(DefPadWord),
    parameter int unsigned       CNT_W    = DefCntW
) (
    input  logic               clk,
    input  logic               reset,
    seg_frame_packer_if.slave  bus
);

    localparam int unsigned      IDX_W   = seg_idx_w(NUM_SEG);
    localparam logic [IDX_W-1:0] LastSeg = IDX_W'(NUM_SEG - 1);
`ifdef SEG_FRAME_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LastRd  = IDX_W'(NUM_SEG);
`else
    localparam logic [IDX_W-1:0] LastRd  = LastSeg;
`endif

    seg_state_e        state_q, state_d;
    logic [IDX_W-1:0]  wr_idx_q, rd_idx_q;
    logic [CNT_W-1:0]  frame_cnt_q;
    logic [IDX_W-1:0]  held_cnt, rd_next_idx, rd_addr;
    logic              in_collect, in_drain, accept, complete, flush_go, close_frame;
    logic              xfer, last_xfer, rd_en;
    logic [DATA_W-1:0] rd_data;

    assign in_collect  = (state_q == COLLECT);
    assign in_drain    = (state_q == DRAIN);
    assign accept      = in_collect && bus.seg_valid;
    assign complete    = accept && (wr_idx_q == LastSeg);
    // Words held once this cycle's accept lands; a flush only acts if non-zero.
    assign held_cnt    = wr_idx_q + {{(IDX_W - 1){1'b0}}, accept};
    assign flush_go    = in_collect && bus.seg_flush && (held_cnt != '0) && !complete;
    assign close_frame = complete || flush_go;
    assign xfer        = in_drain && bus.out_ready;
    assign last_xfer   = xfer && (rd_idx_q == LastRd);
    assign rd_next_idx = rd_idx_q + IDX_W'(1);
    assign rd_en       = close_frame || (xfer && !last_xfer && (rd_next_idx < IDX_W'(NUM_SEG)));
    assign rd_addr     = close_frame ? '0 : rd_next_idx;

    seg_frame_buf #(
        .NUM_SEG  (NUM_SEG),
        .DATA_W   (DATA_W),
        .PAD_WORD (PAD_WORD),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (accept),
        .wr_idx    (wr_idx_q),
        .wr_data   (bus.seg_data),
        .pad_en    (flush_go),
        .pad_start (held_cnt),
        .rd_en     (rd_en),
        .rd_idx    (rd_addr),
        .rd_data   (rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (close_frame) state_d = DRAIN;
            DRAIN:   if (last_xfer)   state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Write/read indices and completed-frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (last_xfer) begin
                wr_idx_q    <= '0;
                rd_idx_q    <= '0;
                frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            end else begin
                if (accept) wr_idx_q <= wr_idx_q + IDX_W'(1);
                if (xfer)   rd_idx_q <= rd_next_idx;
            end
        end
    end

`ifdef SEG_FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [IDX_W-1:0]  pad_cnt;

    assign pad_cnt = IDX_W'(NUM_SEG) - held_cnt;

    // Running XOR of every buffered word; an even pad count cancels out.
    always_comb begin
        csum_d = csum_q;
        if (accept)                  csum_d = csum_d ^ bus.seg_data;
        if (flush_go && pad_cnt[0])  csum_d = csum_d ^ PAD_WORD;
        if (last_xfer)               csum_d = '0;
    end

    // Checksum register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    // FSM outputs; the word after buf[NUM_SEG-1] is the checksum when enabled.
    always_comb begin
        bus.seg_ready = in_collect;
        bus.out_valid = in_drain;
        bus.out_last  = in_drain && (rd_idx_q == LastRd);
`ifdef SEG_FRAME_CHECKSUM_EN
        bus.out_data  = (rd_idx_q == IDX_W'(NUM_SEG)) ? csum_q : rd_data;
`else
        bus.out_data  = rd_data;
`endif
    end

    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_seg_frame_packer.sv
// Scoreboard bench for seg_frame_packer (NUM_SEG=8, DATA_W=32).
module tb_seg_frame_packer;

    localparam int unsigned NUM_SEG = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 16;
    localparam logic [31:0] PAD     = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   xfer_cnt;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] frm [NUM_SEG];
    int          frm_n;
    logic        stalled;
    logic [32:0] held_word;

    seg_frame_packer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    seg_frame_packer #(
        .NUM_SEG  (NUM_SEG),
        .DATA_W   (DATA_W),
        .PAD_WORD (PAD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame: held words, pad fill, optional XOR checksum word.
    task automatic push_frame();
        logic [31:0] w;
        logic [31:0] cs;
        cs = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            w = (i < frm_n) ? frm[i] : PAD;
            cs = cs ^ w;
`ifdef SEG_FRAME_CHECKSUM_EN
            exp_q.push_back('{data: w, last: 1'b0});
`else
            exp_q.push_back('{data: w, last: (i == NUM_SEG - 1)});
`endif
        end
`ifdef SEG_FRAME_CHECKSUM_EN
        exp_q.push_back('{data: cs, last: 1'b1});
`endif
        frm_n = 0;
    endtask

    task automatic send_seg(input logic [31:0] d, input logic fl);
        @(posedge clk);
        #1;
        bus.seg_valid = 1'b1;
        bus.seg_data  = d;
        bus.seg_flush = fl;
        check_eq("seg_ready_collect", bus.seg_ready, 1);
        frm[frm_n] = d;
        frm_n++;
        if (fl || frm_n == NUM_SEG) push_frame();
    endtask

    task automatic send_flush();
        @(posedge clk);
        #1;
        bus.seg_valid = 1'b0;
        bus.seg_flush = 1'b1;
        if (frm_n > 0) push_frame();
    endtask

    // Drop the segment inputs and check whether a drain just began.
    task automatic end_frame(input logic expect_drain, input logic rdy);
        @(posedge clk);
        #1;
        bus.seg_valid = 1'b0;
        bus.seg_flush = 1'b0;
        bus.out_ready = rdy;
        check_eq("first_out_valid", bus.out_valid, expect_drain);
        check_eq("seg_ready_after_close", bus.seg_ready, !expect_drain);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        check_eq("drain_done", exp_q.size(), 0);
        check_eq("idle_after_drain", bus.out_valid, 0);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            check_eq("seg_ready_in_drain", bus.seg_ready, 0);
            if (stalled) check_eq("stall_hold", {bus.out_data, bus.out_last}, held_word);
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_word", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_data", bus.out_data, mon_e.data);
                    check_eq("out_last", bus.out_last, mon_e.last);
                end
                xfer_cnt++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_word = {bus.out_data, bus.out_last};
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        xfer_cnt = 0;
        frm_n    = 0;
        stalled  = 1'b0;
        reset         = 1'b1;
        bus.seg_valid = 1'b0;
        bus.seg_data  = '0;
        bus.seg_flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_seg_ready", bus.seg_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_last", bus.out_last, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_frame_cnt", bus.frame_cnt, 0);
        reset = 1'b0;

        // Flush on an empty buffer is ignored.
        send_flush();
        end_frame(1'b0, 1'b1);

        // Full frame 1..8.
        for (int i = 1; i <= 8; i++) send_seg(32'(i), 1'b0);
        end_frame(1'b1, 1'b1);
        wait_drain();
        check_eq("frame_cnt_1", bus.frame_cnt, 1);

        // Partial frame closed by flush, padded to 8.
        send_seg(32'hA, 1'b0);
        send_seg(32'hB, 1'b0);
        send_seg(32'hC, 1'b0);
        send_flush();
        end_frame(1'b1, 1'b1);
        wait_drain();
        check_eq("frame_cnt_2", bus.frame_cnt, 2);

        // Flush together with the completing accept: one frame only.
        for (int i = 1; i <= 8; i++) send_seg(32'h100 + 32'(i), (i == 8));
        end_frame(1'b1, 1'b1);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_extra_frame", bus.out_valid, 0);
        check_eq("frame_cnt_3", bus.frame_cnt, 3);

        // Back-pressure 1,0,0,1 during drain.
        for (int i = 0; i < 8; i++) send_seg(32'h10 + 32'(i), 1'b0);
        end_frame(1'b1, 1'b1);
        @(posedge clk); #1; bus.out_ready = 1'b0;
        @(posedge clk); #1; bus.out_ready = 1'b0;
        @(posedge clk); #1; bus.out_ready = 1'b1;
        wait_drain();
        check_eq("frame_cnt_4", bus.frame_cnt, 4);

        // Reset after five words of a frame have drained.
        xfer_cnt = 0;
        for (int i = 0; i < 8; i++) send_seg(32'h20 + 32'(i), 1'b0);
        end_frame(1'b1, 1'b1);
        for (int i = 0; i < 50 && xfer_cnt < 5; i++) @(posedge clk);
        check_eq("five_drained", xfer_cnt, 5);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_out_valid", bus.out_valid, 0);
        check_eq("midrst_seg_ready", bus.seg_ready, 1);
        check_eq("midrst_frame_cnt", bus.frame_cnt, 0);
        exp_q.delete();
        frm_n = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) send_seg(32'h30 + 32'(i), 1'b0);
        end_frame(1'b1, 1'b1);
        wait_drain();
        check_eq("frame_cnt_after_rst", bus.frame_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
